nanorv32_ahb_console: RTL
=========================

Name: nanorv32_ahb_console

Overview:
AHB-lite slave peripheral for the nanorv32 simulation platform. It replaces PC-snooping for printf and end-of-test detection. Firmware writes characters to TXDATA; they are buffered in a FIFO and drained to the bench over a valid/ready byte stream. A write to TESTEND reports the pass/fail verdict, which is released to the bench only once the FIFO has drained. It sits on the nanorv32_simpleahb data bus, downstream of the CPU; the testbench consumes its outputs.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; power of two, minimum 2.
ADDR_W, 4, number of HADDR bits decoded (byte offset within the slave window).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  ADDR_W  byte address (low bits)
htrans  in  2  AHB transfer type; only NONSEQ/SEQ (bit1=1) are acted on
hwrite  in  1  1 = write
hsize  in  3  ignored; all accesses are treated as 32-bit
hwdata  in  32  write data (data phase)
hready  in  1  bus-wide HREADY
hrdata  out  32  read data
hreadyout  out  1  slave ready
hresp  out  1  always 0 (OKAY)
char_valid  out  1  FIFO head byte available
char_data  out  8  FIFO head byte
char_ready  in  1  bench accepts byte
test_done  out  1  sticky verdict-valid flag
test_pass  out  1  1 when the verdict code is 32'hCAFFE000
test_code  out  32  raw value written to TESTEND

Behaviour:
- Reset (async, rst_n=0): hrdata=0, hreadyout=1, hresp=0, char_valid=0, char_data=0, test_done=0, test_pass=0, test_code=0. FIFO is emptied; pending address phase is cleared. Reset mid-stall aborts the transfer.
- Address phase is captured when hsel & htrans[1] & hready. Stored: offset, hwrite. Access acts in the following (data) cycle.
- Register map:
  - 0x0 TXDATA: W: hwdata[7:0] is pushed. R: 0.
  - 0x4 STATUS: R: bit0 empty, bit1 full, bits[15:8] level, bit16 test_pending. W: ignored.
  - 0x8 TESTEND: W: latch code. R: test_code.
  - Other offsets: read 0, writes ignored.
- Reads are zero-wait. hrdata is valid in the data phase and 0 otherwise.
- TXDATA write while the FIFO is full: hreadyout=0 (wait states) until level < FIFO_DEPTH. The push happens in the cycle hreadyout=1. A pop in the same cycle as the full condition frees space; hreadyout rises the next cycle.
- FIFO push and pop in the same cycle leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Output stream: char_valid = !empty. char_data is the head byte. A pop occurs on char_valid & char_ready. char_data is stable while valid & !ready. A pushed byte appears on char_valid the cycle after the push (1-cycle latency when empty).
- TESTEND write: latch test_code=hwdata and set test_pending=1. The first write wins; later TESTEND writes are ignored until reset.
- test_done rises the first cycle where test_pending & empty, and is sticky. test_pass = (test_code==32'hCAFFE000) and is valid when test_done=1.
- TXDATA writes after TESTEND are still accepted and delay test_done until drained.

Optional Feature:
Macro: NANORV32_CONSOLE_IRQ_EN.
- Defined: adds output irq (1 bit) and register 0xC CTRL.
  - CTRL bit0 ien; CTRL bits[7:4] threshold thr.
  - irq = ien & (level <= thr), registered (1-cycle delay after a level change).
  - CTRL reset value 0.
- Not defined: no irq port; offset 0xC behaves as unmapped.

Decomposition:
- Package nanorv32_console_pkg holds:
  - register offsets: CONSOLE_TXDATA=0x0, CONSOLE_STATUS=0x4, CONSOLE_TESTEND=0x8, CONSOLE_CTRL=0xC
  - magic codes: TEST_PASS_CODE=32'hCAFFE000, TEST_FAIL_CODE=32'hDEAD0000
  - HTRANS encodings
- Sub-module nanorv32_sync_fifo (parameterised DEPTH/WIDTH). Its outputs are full, empty and level, with push/pop semantics as above. The top level holds the AHB decode, stall logic and verdict logic.

Test Plan:
- Write 0x48, 0x69, 0x0A to TXDATA with char_ready=1 -> char_data sequence 0x48, 0x69, 0x0A, each char_valid one cycle after its push; STATUS reads empty=1 afterward.
- char_ready=0, 8 TXDATA writes then a 9th -> the 9th stalls (hreadyout=0). STATUS shows full=1, level=8. Release char_ready for 1 cycle -> the 9th completes; the byte order is preserved across the pointer wrap.
- char_ready=0, write 3 chars then TESTEND=0xCAFFE000 -> test_done stays 0. Enable char_ready -> test_done=1 the cycle the FIFO empties, test_pass=1, test_code=0xCAFFE000.
- TESTEND=0xDEAD0000 then TESTEND=0xCAFFE000 -> test_code=0xDEAD0000, test_pass=0 (first write wins).
- Assert rst_n=0 during a full-FIFO stall -> all outputs return to reset values, hreadyout=1, STATUS level=0.
- (IRQ_EN) CTRL=0x21 (thr=2, ien=1), push 4 chars with char_ready=0 -> irq=0. Drain to level 2 -> irq=1 one cycle later.

Source files
------------

// File: rtl/nanorv32_console_pkg.sv
// nanorv32_console_pkg
//   Shared constants for the nanorv32 AHB console peripheral: register
//   offsets within the slave window, verdict magic codes and AHB HTRANS
//   encodings.
package nanorv32_console_pkg;

  // Register byte offsets
  localparam logic [7:0] CONSOLE_TXDATA  = 8'h0;
  localparam logic [7:0] CONSOLE_STATUS  = 8'h4;
  localparam logic [7:0] CONSOLE_TESTEND = 8'h8;
  localparam logic [7:0] CONSOLE_CTRL    = 8'hC;

  // Verdict codes written by firmware to TESTEND
  localparam logic [31:0] TEST_PASS_CODE = 32'hCAFFE000;
  localparam logic [31:0] TEST_FAIL_CODE = 32'hDEAD0000;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY are ignored.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/nanorv32_sync_fifo.sv
// nanorv32_sync_fifo
//   Single-clock FIFO with registered occupancy.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, wdata     write request/data (ignored while full)
//     pop             read request (ignored while empty)
//     rdata           head entry (valid while !empty)
//     full, empty     occupancy flags
//     level           number of stored entries (0..DEPTH)
//   DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module nanorv32_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full    = (level_q == LVL_W'(DEPTH));
    empty   = (level_q == '0);
    level   = level_q;
    rdata   = mem_q[rd_ptr_q];
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; entries are only observed when level says so.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/nanorv32_ahb_console.sv
// nanorv32_ahb_console
//   AHB-lite slave console for the nanorv32 simulation platform. Firmware
//   writes characters to TXDATA, which are buffered and streamed out over
//   char_valid/char_ready. A TESTEND write records the verdict, released on
//   test_done only once all buffered characters have drained.
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     hsel/haddr/htrans/hwrite/hsize AHB address phase (hsize ignored)
//     hwdata, hready                 AHB data phase
//     hrdata, hreadyout, hresp       slave response (hresp always OKAY)
//     char_valid/char_data/char_ready character stream to the bench
//     test_done/test_pass/test_code  verdict
//     irq                            only with NANORV32_CONSOLE_IRQ_EN
//   Optional feature macro: NANORV32_CONSOLE_IRQ_EN adds CTRL (0xC) and irq.
module nanorv32_ahb_console
  import nanorv32_console_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              test_done,
  output logic              test_pass,
  output logic [31:0]       test_code
`ifdef NANORV32_CONSOLE_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] OFS_TXDATA  = ADDR_W'(CONSOLE_TXDATA);
  localparam logic [ADDR_W-1:0] OFS_STATUS  = ADDR_W'(CONSOLE_STATUS);
  localparam logic [ADDR_W-1:0] OFS_TESTEND = ADDR_W'(CONSOLE_TESTEND);
`ifdef NANORV32_CONSOLE_IRQ_EN
  localparam logic [ADDR_W-1:0] OFS_CTRL    = ADDR_W'(CONSOLE_CTRL);
`endif

  // Pending data phase
  logic              dphase_q, dphase_d;
  logic              dwrite_q, dwrite_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;

  // Verdict state
  logic              pending_q, pending_d;
  logic              done_q, done_d;
  logic [31:0]       code_q, code_d;

  // FIFO interface
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;

  logic              wr_tx, wr_testend, rd_access;
  logic [31:0]       status_word;
  logic              unused_ok;

  assign unused_ok = ^{hsize, htrans[0]};

  always_comb begin
    dphase_d = dphase_q;
    dwrite_d = dwrite_q;
    daddr_d  = daddr_q;
    // The data phase only advances while the bus is ready; during our own
    // stall hready is low, so the stalled TXDATA write stays registered.
    if (hready) begin
      dphase_d = hsel & htrans_active(htrans);
      dwrite_d = hwrite;
      daddr_d  = haddr;
    end
  end

  always_comb begin
    wr_tx      = dphase_q & dwrite_q & (daddr_q == OFS_TXDATA);
    wr_testend = dphase_q & dwrite_q & (daddr_q == OFS_TESTEND);
    rd_access  = dphase_q & ~dwrite_q;

    hreadyout  = ~(wr_tx & fifo_full);
    hresp      = 1'b0;
    fifo_push  = wr_tx & ~fifo_full;
    fifo_pop   = char_ready;

    char_valid = ~fifo_empty;
    char_data  = fifo_empty ? '0 : fifo_rdata;

    // First TESTEND write wins until reset.
    pending_d  = pending_q | wr_testend;
    code_d     = (wr_testend & ~pending_q) ? hwdata : code_q;

    test_done  = done_q | (pending_q & fifo_empty);
    done_d     = test_done;
    test_pass  = (code_q == TEST_PASS_CODE);
    test_code  = code_q;

    status_word        = '0;
    status_word[0]     = fifo_empty;
    status_word[1]     = fifo_full;
    status_word[15:8]  = 8'(fifo_level);
    status_word[16]    = pending_q;
  end

`ifdef NANORV32_CONSOLE_IRQ_EN
  logic       ien_q, ien_d;
  logic [3:0] thr_q, thr_d;
  logic       irq_q, irq_d;
  logic       wr_ctrl;

  always_comb begin
    wr_ctrl = dphase_q & dwrite_q & (daddr_q == OFS_CTRL);
    ien_d   = ien_q;
    thr_d   = thr_q;
    if (wr_ctrl) begin
      ien_d = hwdata[0];
      thr_d = hwdata[7:4];
    end
    irq_d = ien_q & (32'(fifo_level) <= 32'(thr_q));
    irq   = irq_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ien_q <= 1'b0;
      thr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      thr_q <= thr_d;
      irq_q <= irq_d;
    end
  end
`endif

  always_comb begin
    hrdata = '0;
    if (rd_access) begin
      case (daddr_q)
        OFS_STATUS:  hrdata = status_word;
        OFS_TESTEND: hrdata = code_q;
`ifdef NANORV32_CONSOLE_IRQ_EN
        OFS_CTRL:    hrdata = {24'h0, thr_q, 3'b000, ien_q};
`endif
        default:     hrdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dphase_q  <= 1'b0;
      dwrite_q  <= 1'b0;
      daddr_q   <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      code_q    <= '0;
    end else begin
      dphase_q  <= dphase_d;
      dwrite_q  <= dwrite_d;
      daddr_q   <= daddr_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      code_q    <= code_d;
    end
  end

  nanorv32_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (hwdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule
